// File: rtl/interrupt_request_controller_pkg.sv
// Shared constants for the interrupt request controller: register word offsets,
// CTRL bit positions, request FSM encodings and the timer's cause ID.
package interrupt_request_controller_pkg;

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_ENABLE  = 3'd1;
  localparam logic [2:0] REG_PENDING = 3'd2;
  localparam logic [2:0] REG_CMP     = 3'd3;
  localparam logic [2:0] REG_COUNT   = 3'd4;
  localparam logic [2:0] REG_CAUSE   = 3'd5;

  localparam int CTRL_GIE  = 0;
  localparam int CTRL_TEN  = 1;
  localparam int CTRL_AUTO = 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQUEST = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;
  localparam logic [1:0] ST_RETIRE  = 2'd3;

  localparam logic [3:0] CAUSE_TIMER = 4'd0;

endpackage

// File: rtl/interrupt_request_controller_irq_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for one external interrupt line.
// The one-cycle pulse appears two cycles after the pin rises; no backpressure.
module irq_edge_sync
  import interrupt_request_controller_pkg::*;
(
  input  logic I_clk,
  input  logic I_rst,
  input  logic irq_in,
  output logic irq_rise
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign irq_rise = sync2_q & ~prev_q;

endmodule

// File: rtl/interrupt_request_controller.sv
// Memory-mapped interrupt request controller: timer + N_EXT edge lines -> pending -> one request.
// Pin-to-pending 3 cycles, pending-to-request 1 cycle; a raised request is held until the handler goes busy.
module interrupt_request_controller
  import interrupt_request_controller_pkg::*;
#(
  parameter int ADDRESS_BITS = 32,
  parameter int N_EXT        = 4,
  parameter int PRESCALE     = 1
) (
  input  logic                    I_clk,
  input  logic                    I_rst,
  input  logic [N_EXT-1:0]        I_ext_irq,
  input  logic                    I_we,
  input  logic                    I_re,
  input  logic [ADDRESS_BITS-1:0] I_addr,
  input  logic [ADDRESS_BITS-1:0] I_wdata,
  output logic [ADDRESS_BITS-1:0] O_rdata,
  input  logic                    I_int_happening,
  input  logic                    I_int_done,
  output logic                    O_request,
  output logic [3:0]              O_cause,
  output logic [N_EXT:0]          O_pending
);

  localparam int NP = N_EXT + 1;

  logic [2:0]              ctrl_q;
  logic [NP-1:0]           enable_q, pending_q, pending_d;
  logic [NP-1:0]           hw_set, w1c_mask, svc_clr, eligible;
  logic [ADDRESS_BITS-1:0] cmp_q, count_q, rdata_q, rdata_d;
  logic [31:0]             presc_q;
  logic [1:0]              state_q;
  logic [3:0]              cause_q, winner;
  logic                    request_q;
  logic [2:0]              sel;
  logic                    tick, timer_hit, wr_timer;
  logic                    unused_addr;

  assign sel         = I_addr[4:2];
  assign unused_addr = ^{I_addr[ADDRESS_BITS-1:5], I_addr[1:0]};

  for (genvar k = 0; k < N_EXT; k++) begin : g_sync
    irq_edge_sync u_sync (
      .I_clk    (I_clk),
      .I_rst    (I_rst),
      .irq_in   (I_ext_irq[k]),
      .irq_rise (hw_set[k+1])
    );
  end

  assign tick      = ctrl_q[CTRL_TEN] && (presc_q == 32'(PRESCALE - 1));
  assign timer_hit = tick && (count_q == cmp_q);
  assign hw_set[0] = timer_hit;
  assign wr_timer  = I_we && (sel == REG_CMP || sel == REG_COUNT);

  // Hardware sets are OR-ed in last so they win over both W1C and retirement.
  assign w1c_mask  = (I_we && sel == REG_PENDING) ? I_wdata[NP-1:0] : '0;
  assign pending_d = (pending_q & ~w1c_mask & ~svc_clr) | hw_set;
  assign eligible  = pending_q & enable_q;

  always_comb begin
    svc_clr = '0;
    winner  = CAUSE_TIMER;
    for (int k = 0; k < NP; k++)
      svc_clr[k] = (state_q == ST_SERVICE) && I_int_done && (cause_q == 4'(k));
    for (int k = NP - 1; k >= 0; k--)
      if (eligible[k]) winner = 4'(k);
  end

  always_comb begin
    rdata_d = '0;
    case (sel)
      REG_CTRL:    rdata_d = ADDRESS_BITS'(ctrl_q);
      REG_ENABLE:  rdata_d = ADDRESS_BITS'(enable_q);
      REG_PENDING: rdata_d = ADDRESS_BITS'(pending_q);
      REG_CMP:     rdata_d = cmp_q;
      REG_COUNT:   rdata_d = count_q;
      REG_CAUSE:   rdata_d = ADDRESS_BITS'(cause_q);
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      ctrl_q    <= '0;
      enable_q  <= '0;
      pending_q <= '0;
      cmp_q     <= '1;
      count_q   <= '0;
      presc_q   <= '0;
      rdata_q   <= '0;
    end else begin
      pending_q <= pending_d;
      if (I_re) rdata_q <= rdata_d;
      if (I_we && sel == REG_ENABLE) enable_q <= I_wdata[NP-1:0];
      if (I_we && sel == REG_CMP) cmp_q <= I_wdata;

      if (wr_timer) presc_q <= '0;
      else if (ctrl_q[CTRL_TEN]) presc_q <= tick ? 32'd0 : presc_q + 32'd1;

      if (I_we && sel == REG_COUNT) count_q <= I_wdata;
      else if (tick) begin
        if (!timer_hit) count_q <= count_q + ADDRESS_BITS'(1);
        else if (ctrl_q[CTRL_AUTO]) count_q <= '0;
      end

      // A one-shot match stops the timer unless software rewrites CTRL in the same cycle.
      if (I_we && sel == REG_CTRL) ctrl_q <= I_wdata[2:0];
      else if (timer_hit && !ctrl_q[CTRL_AUTO]) ctrl_q[CTRL_TEN] <= 1'b0;
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q   <= ST_IDLE;
      request_q <= 1'b0;
      cause_q   <= CAUSE_TIMER;
    end else begin
      case (state_q)
        ST_IDLE:
          if (ctrl_q[CTRL_GIE] && |eligible) begin
            cause_q   <= winner;
            request_q <= 1'b1;
            state_q   <= ST_REQUEST;
          end
        ST_REQUEST:
          if (I_int_happening) begin
            request_q <= 1'b0;
            state_q   <= ST_SERVICE;
          end
        ST_SERVICE:
          if (I_int_done) state_q <= ST_RETIRE;
        ST_RETIRE:
          if (!I_int_happening) state_q <= ST_IDLE;
        default: begin
          request_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign O_rdata   = rdata_q;
  assign O_request = request_q;
  assign O_cause   = cause_q;
  assign O_pending = pending_q;

endmodule

// File: tb/tb_interrupt_request_controller.sv
// Bench for interrupt_request_controller: register-map vector table plus timer, priority,
// masking, set/clear race, re-fire and reset sequences; bus reads are scored from a queue.
module tb_interrupt_request_controller;

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b1;
  logic [3:0]  I_ext_irq = '0;
  logic        I_we = 1'b0, I_re = 1'b0;
  logic [31:0] I_addr = '0, I_wdata = '0;
  logic [31:0] O_rdata;
  logic        I_int_happening = 1'b0, I_int_done = 1'b0;
  logic        O_request;
  logic [3:0]  O_cause;
  logic [4:0]  O_pending;

  int tests = 0;
  int fails = 0;

  interrupt_request_controller #(.ADDRESS_BITS(32), .N_EXT(4), .PRESCALE(1)) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_ext_irq(I_ext_irq), .I_we(I_we), .I_re(I_re),
    .I_addr(I_addr), .I_wdata(I_wdata), .O_rdata(O_rdata),
    .I_int_happening(I_int_happening), .I_int_done(I_int_done),
    .O_request(O_request), .O_cause(O_cause), .O_pending(O_pending)
  );

  always #5 I_clk = ~I_clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Read data appears the cycle after I_re; compare it on the following falling edge.
  logic chk_due = 1'b0;
  always @(posedge I_clk) chk_due <= I_re && !I_rst;
  always @(negedge I_clk) begin
    if (chk_due) begin
      if (sb_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else begin
        sb_t e;
        e = sb_q.pop_front();
        check(e.name, O_rdata, e.exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge I_clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    I_we = 1'b1; I_addr = a; I_wdata = d;
    @(negedge I_clk);
    I_we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    sb_t e;
    e.name = name; e.exp = exp;
    sb_q.push_back(e);
    I_re = 1'b1; I_addr = a;
    @(negedge I_clk);
    I_re = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!O_request && n < 20) begin
      tick(1);
      n++;
    end
    check(name, {31'd0, O_request}, 32'd1);
  endtask

  // Handler model: go busy, pulse done, go idle.
  task automatic service();
    I_int_happening = 1'b1;
    tick(2);
    I_int_done = 1'b1;
    tick(1);
    I_int_done = 1'b0;
    I_int_happening = 1'b0;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b0, 32'h00, 32'h0,        32'h0};
    vt[1]  = '{1'b0, 32'h04, 32'h0,        32'h0};
    vt[2]  = '{1'b0, 32'h08, 32'h0,        32'h0};
    vt[3]  = '{1'b0, 32'h0C, 32'h0,        32'hFFFF_FFFF};
    vt[4]  = '{1'b0, 32'h10, 32'h0,        32'h0};
    vt[5]  = '{1'b0, 32'h14, 32'h0,        32'h0};
    vt[6]  = '{1'b1, 32'h04, 32'hFFFF_FFFF, 32'h1F};
    vt[7]  = '{1'b1, 32'h0C, 32'h0000_1234, 32'h1234};
    vt[8]  = '{1'b1, 32'h10, 32'h0000_0055, 32'h55};
    vt[9]  = '{1'b1, 32'h00, 32'h0000_00FD, 32'h5};
    vt[10] = '{1'b1, 32'h18, 32'hDEAD_BEEF, 32'h0};
    vt[11] = '{1'b1, 32'h1C, 32'h1234_5678, 32'h0};
    vt[12] = '{1'b1, 32'h08, 32'hFFFF_FFFF, 32'h0};
    vt[13] = '{1'b1, 32'h00, 32'h0,        32'h0};

    tick(2);
    check("rst_request", {31'd0, O_request}, 32'd0);
    check("rst_pending", {27'd0, O_pending}, 32'd0);
    check("rst_rdata", O_rdata, 32'd0);
    I_rst = 1'b0;
    tick(1);

    for (int i = 0; i < 14; i++) begin
      if (vt[i].we) wr(vt[i].addr, vt[i].wdata);
      rd(vt[i].addr, vt[i].exp, $sformatf("vec%0d", i));
    end
    rd(32'h0C, 32'h1234, "rd_cmp");
    tick(2);
    check("rdata_hold", O_rdata, 32'h1234);

    // Timer one-shot
    wr(32'h04, 32'h1);
    wr(32'h0C, 32'd9);
    wr(32'h10, 32'd0);
    wr(32'h00, 32'h3);
    tick(9);
    check("tmr_pend_early", {27'd0, O_pending}, 32'h0);
    tick(1);
    check("tmr_pend_set", {27'd0, O_pending}, 32'h1);
    check("tmr_req_early", {31'd0, O_request}, 32'd0);
    tick(1);
    check("tmr_req", {31'd0, O_request}, 32'd1);
    check("tmr_cause", {28'd0, O_cause}, 32'd0);
    rd(32'h00, 32'h1, "tmr_ten_clr");
    rd(32'h10, 32'd9, "tmr_count_hold");

    // Handshake
    check("hs_req_held", {31'd0, O_request}, 32'd1);
    I_int_happening = 1'b1;
    tick(1);
    check("hs_req_drop", {31'd0, O_request}, 32'd0);
    tick(1);
    I_int_done = 1'b1;
    tick(1);
    I_int_done = 1'b0;
    check("hs_pend_clr", {27'd0, O_pending}, 32'h0);
    I_int_happening = 1'b0;
    tick(3);
    check("hs_no_rereq", {31'd0, O_request}, 32'd0);

    // Priority
    wr(32'h04, 32'h1F);
    I_ext_irq = 4'b0101;
    wait_req("pri_req1");
    check("pri_cause1", {28'd0, O_cause}, 32'd1);
    check("pri_pend", {27'd0, O_pending}, 32'h0A);
    service();
    wait_req("pri_req2");
    check("pri_cause2", {28'd0, O_cause}, 32'd3);
    service();
    check("pri_pend_empty", {27'd0, O_pending}, 32'h0);
    I_ext_irq = 4'b0000;

    // Masking and W1C
    wr(32'h04, 32'h1);
    I_ext_irq = 4'b0010;
    tick(4);
    check("mask_pend", {27'd0, O_pending}, 32'h4);
    check("mask_noreq", {31'd0, O_request}, 32'd0);
    rd(32'h08, 32'h4, "mask_rd");
    wr(32'h08, 32'h4);
    rd(32'h08, 32'h0, "w1c_rd");

    // W1C in the same cycle as a fresh edge
    I_ext_irq = 4'b0000;
    tick(4);
    I_ext_irq = 4'b0010;
    tick(2);
    wr(32'h08, 32'h4);
    check("race_set_wins", {27'd0, O_pending}, 32'h4);
    wr(32'h08, 32'h4);
    check("race_clr", {27'd0, O_pending}, 32'h0);
    I_ext_irq = 4'b0000;

    // Re-fire landing on the done cycle
    wr(32'h04, 32'h1F);
    tick(3);
    I_ext_irq = 4'b0001;
    wait_req("rf_req1");
    check("rf_cause1", {28'd0, O_cause}, 32'd1);
    I_ext_irq = 4'b0000;
    I_int_happening = 1'b1;
    tick(1);
    check("rf_req_drop", {31'd0, O_request}, 32'd0);
    tick(3);
    I_ext_irq = 4'b0001;
    tick(2);
    I_int_done = 1'b1;
    tick(1);
    I_int_done = 1'b0;
    check("rf_pend_kept", {27'd0, O_pending}, 32'h2);
    I_int_happening = 1'b0;
    tick(1);
    check("rf_idle_noreq", {31'd0, O_request}, 32'd0);
    tick(1);
    check("rf_rereq", {31'd0, O_request}, 32'd1);
    check("rf_cause2", {28'd0, O_cause}, 32'd1);
    service();
    I_ext_irq = 4'b0000;
    check("rf_pend_clr", {27'd0, O_pending}, 32'h0);

    // Reset mid-REQUEST
    wr(32'h0C, 32'd1000);
    wr(32'h00, 32'h3);
    I_ext_irq = 4'b1000;
    wait_req("rst_req");
    check("rst_cause_pre", {28'd0, O_cause}, 32'd4);
    #2 I_rst = 1'b1;
    #1;
    check("mid_rst_req", {31'd0, O_request}, 32'd0);
    check("mid_rst_pend", {27'd0, O_pending}, 32'h0);
    check("mid_rst_cause", {28'd0, O_cause}, 32'd0);
    check("mid_rst_rdata", O_rdata, 32'd0);
    I_ext_irq = 4'b0000;
    tick(2);
    I_rst = 1'b0;
    tick(1);
    rd(32'h00, 32'h0, "post_rst_ctrl");
    rd(32'h10, 32'h0, "post_rst_count");
    rd(32'h0C, 32'hFFFF_FFFF, "post_rst_cmp");
    rd(32'h04, 32'h0, "post_rst_enable");
    tick(3);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/interrupt_request_controller.md
Name: interrupt_request_controller

Overview:
- Initiator side of the core's interrupt handshake. Collects a timer compare event and N_EXT external interrupt lines into a pending register, prioritises them, and drives the single request line into the interrupt handler.
- Tracks the handler's busy/done indications so that exactly one request is raised per service.
- Sits beside the core as a memory-mapped peripheral on the data-memory bus.

Parameters:
- ADDRESS_BITS, 32, bus address and data width.
- N_EXT, 4, number of external interrupt lines (1..15).
- PRESCALE, 1, number of I_clk cycles per timer tick (>=1).

Ports:
- I_clk  in  1  clock
- I_rst  in  1  reset, asynchronous, active-high
- I_ext_irq  in  N_EXT  asynchronous external lines; active-high, rising-edge triggered
- I_we  in  1  bus write strobe
- I_re  in  1  bus read strobe
- I_addr  in  ADDRESS_BITS  byte address; only bits [4:2] are decoded
- I_wdata  in  ADDRESS_BITS  write data
- O_rdata  out  ADDRESS_BITS  read data, registered
- I_int_happening  in  1  handler busy (its state is not WAIT)
- I_int_done  in  1  handler has reached ISR_DONE (its done flag)
- O_request  out  1  interrupt request to the handler
- O_cause  out  4  ID of the source being requested or serviced; 0 = timer, k = I_ext_irq[k-1]
- O_pending  out  N_EXT+1  current pending vector

Behaviour:
- Reset values:
  - O_request=0, O_cause=0, O_pending=0, O_rdata=0.
  - CTRL=0, ENABLE=0, CMP=all ones, COUNT=0, prescaler=0, synchronisers=0, state=IDLE.
- Register map (word offsets):
  - 0x00 CTRL: bit0 GIE, bit1 TEN, bit2 AUTO_RELOAD.
  - 0x04 ENABLE mask [N_EXT:0].
  - 0x08 PENDING: read returns the vector; a write clears every bit written as 1 (W1C).
  - 0x0C CMP.
  - 0x10 COUNT: read/write.
  - 0x14 CAUSE: read-only, returns O_cause.
  - Unmapped offsets read 0; writes to them are ignored.
- O_rdata updates on the cycle after I_re and holds its value otherwise.
- External lines:
  - Each line passes through a 2-flop synchroniser followed by a rising-edge detector.
  - An edge sets pending[k]; the total latency from the pin change to the pending bit is 3 cycles.
- Timer:
  - While TEN=1, COUNT increments once every PRESCALE cycles.
  - When COUNT==CMP on a tick: set pending[0]. If AUTO_RELOAD=1, COUNT wraps to 0; otherwise TEN is cleared and COUNT holds.
  - A bus write to COUNT or CMP resets the prescaler.
  - COUNT wraps naturally at 2^ADDRESS_BITS-1.
- Pending-bit precedence: a hardware set wins over a W1C in the same cycle.
- Eligible set = pending & ENABLE. Priority: the lowest ID wins.
- State machine:
  - IDLE: if GIE=1 and the eligible set is non-zero, latch the winner into O_cause, assert O_request, and go to REQUEST.
  - REQUEST: hold O_request=1 and keep O_cause frozen until I_int_happening=1, then drop O_request and go to SERVICE. The request is never withdrawn, even if GIE, ENABLE or pending change during this state.
  - SERVICE: wait for I_int_done=1, then clear pending[O_cause] and go to RETIRE.
  - RETIRE: wait for I_int_happening=0, then go to IDLE. The earliest possible re-request is the cycle after IDLE is entered.
  - Any unused state encoding returns to IDLE.
- Re-arming: a source that re-fires during SERVICE stays pending.
  - Its pending bit is cleared only at the I_int_done cycle.
  - An edge arriving in that same cycle wins and leaves the bit set.
- The handler samples O_request only in its WAIT state; requests raised while it is busy are therefore deferred by construction.
- Reset mid-operation returns everything to reset values immediately. The handler is reset by the same I_rst.

Decomposition:
- Shared package holds:
  - the register offset constants;
  - the CTRL bit indices;
  - the state encodings IDLE/REQUEST/SERVICE/RETIRE;
  - the cause ID for the timer (0).
- One sub-module, irq_edge_sync: a per-line 2-flop synchroniser plus rising-edge pulse, instantiated N_EXT times via generate.

Test Plan:
- Timer one-shot: CMP=9, CTRL=0x3, ENABLE=0x1, PRESCALE=1 -> pending[0] set 10 cycles after TEN, O_request=1 with O_cause=0, TEN reads 0 afterwards.
- Handshake: hold I_int_happening=1 two cycles after request -> O_request drops the next cycle; pulse I_int_done -> pending[0]=0; drop I_int_happening -> state back to IDLE, no second request.
- Priority: raise I_ext_irq[2] and I_ext_irq[0] in the same cycle with ENABLE=0x1F, GIE=1 -> first O_cause=1, second request after retire has O_cause=3.
- Masking/W1C: edge on I_ext_irq[1] with ENABLE=0x1 -> PENDING reads 0x4 and there is no request; write PENDING=0x4 -> reads 0.
- Simultaneous set/clear: W1C of bit 2 in the same cycle as a new edge on I_ext_irq[1] -> bit stays 1. Source re-fires during SERVICE -> a fresh request follows RETIRE.
- Reset mid-REQUEST: assert I_rst while O_request=1 -> O_request, O_pending, COUNT and CTRL are all 0 immediately.
